// File: rtl/slave_port_pkg.sv
// Shared types and helpers for the bus-slave serial transmit port.
package slave_port_pkg;

  // Word width used when the instantiating block does not override it.
  localparam int DEFAULT_DATA_WIDTH = 8;

  // Transmit FSM: waiting for a word, or shifting a frame onto the line.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Width of the bit-position counter for a word of dw bits.
  function automatic int cnt_width(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// Load/shift register for one outgoing word. The bit currently on the line
// is held in its own flop so the serial output is registered. A bit counter
// tracks the position of that bit and a registered flag marks the last bit.
module tx_shift_reg
  import slave_port_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  srst,
  input  logic                  load,
  input  logic                  advance,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  ser_bit,
  output logic                  last
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);
  // Counter value of the second-to-last bit: advancing from here lands on the last bit.
  localparam logic [CNT_W-1:0] PENULT = CNT_W'(DATA_WIDTH - 2);

  logic [DATA_WIDTH-1:0] shreg_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  bit_r;
  logic                  last_r;

  logic                  first_s;
  logic [DATA_WIDTH-1:0] rest_s;
  logic                  front_s;
  logic [DATA_WIDTH-1:0] shifted_s;

  // Select the bit order: which bit leaves first and which way the rest moves.
  always_comb begin
    first_s   = 1'b0;
    rest_s    = '0;
    front_s   = 1'b0;
    shifted_s = '0;
    if (LSB_FIRST) begin
      first_s   = din[0];
      rest_s    = {1'b0, din[DATA_WIDTH-1:1]};
      front_s   = shreg_r[0];
      shifted_s = {1'b0, shreg_r[DATA_WIDTH-1:1]};
    end else begin
      first_s   = din[DATA_WIDTH-1];
      rest_s    = {din[DATA_WIDTH-2:0], 1'b0};
      front_s   = shreg_r[DATA_WIDTH-1];
      shifted_s = {shreg_r[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // Load puts the first bit straight on the line; advance moves the next bit out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= '0;
      cnt_r   <= '0;
      bit_r   <= 1'b0;
      last_r  <= 1'b0;
    end else if (srst || clear) begin
      shreg_r <= '0;
      cnt_r   <= '0;
      bit_r   <= 1'b0;
      last_r  <= 1'b0;
    end else if (load) begin
      shreg_r <= rest_s;
      cnt_r   <= '0;
      bit_r   <= first_s;
      last_r  <= 1'b0;
    end else if (advance) begin
      shreg_r <= shifted_s;
      cnt_r   <= cnt_r + CNT_W'(1);
      bit_r   <= front_s;
      last_r  <= (cnt_r == PENULT);
    end else begin
      shreg_r <= shreg_r;
      cnt_r   <= cnt_r;
      bit_r   <= bit_r;
      last_r  <= last_r;
    end
  end

  assign ser_bit = bit_r;
  assign last    = last_r;

endmodule

// File: rtl/slave_tx_serializer.sv
// Parallel-to-serial transmit port for bus slaves. Words are accepted via a
// valid/ready handshake gated by master_ready, captured at the handshake and
// shifted out one bit per clock with a qualifying strobe. An optional holding
// register lets a second word queue behind the one being shifted so frames
// follow each other with no idle cycle.
module slave_tx_serializer
  import slave_port_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit BUFFERED   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  srst,
  input  logic                  master_ready,
  input  logic                  slave_valid,
  input  logic [DATA_WIDTH-1:0] datain,
  output logic                  slave_ready,
  output logic                  tx_data,
  output logic                  tx_valid,
  output logic                  slave_tx_done,
  output logic                  busy
);

  state_e                state_r;
  state_e                state_nxt_s;
  logic [DATA_WIDTH-1:0] hold_r;
  logic                  hold_full_r;
  logic                  hold_full_nxt_s;
  logic                  hold_load_s;
  logic                  slave_ready_r;
  logic                  busy_r;
  logic                  tx_valid_r;

  logic                  accept_s;
  logic                  load_s;
  logic                  adv_s;
  logic                  clr_s;
  logic [DATA_WIDTH-1:0] load_word_s;
  logic                  ser_bit_s;
  logic                  last_s;

  assign accept_s = slave_valid & master_ready & slave_ready_r;

  // Next-state, shifter control and hold-register control.
  always_comb begin
    state_nxt_s     = state_r;
    hold_full_nxt_s = hold_full_r;
    hold_load_s     = 1'b0;
    load_s          = 1'b0;
    adv_s           = 1'b0;
    clr_s           = 1'b0;
    load_word_s     = datain;
    case (state_r)
      IDLE: begin
        // An idle accept bypasses the hold register straight into the shifter.
        if (accept_s) begin
          load_s      = 1'b1;
          state_nxt_s = SHIFT;
        end else begin
          clr_s = 1'b1;
        end
      end
      SHIFT: begin
        if (last_s) begin
          // Chain the next word in with no gap if one is held or arriving now.
          if (hold_full_r) begin
            load_s          = 1'b1;
            load_word_s     = hold_r;
            hold_full_nxt_s = 1'b0;
          end else if (accept_s) begin
            load_s = 1'b1;
          end else begin
            clr_s       = 1'b1;
            state_nxt_s = IDLE;
          end
        end else begin
          adv_s = 1'b1;
          if (accept_s && (BUFFERED == 1'b1)) begin
            hold_load_s     = 1'b1;
            hold_full_nxt_s = 1'b1;
          end else begin
            hold_load_s = 1'b0;
          end
        end
      end
      default: begin
        clr_s           = 1'b1;
        state_nxt_s     = IDLE;
        hold_full_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state, hold register and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      hold_r        <= '0;
      hold_full_r   <= 1'b0;
      slave_ready_r <= 1'b1;
      busy_r        <= 1'b0;
      tx_valid_r    <= 1'b0;
    end else if (srst) begin
      state_r       <= IDLE;
      hold_r        <= '0;
      hold_full_r   <= 1'b0;
      slave_ready_r <= 1'b1;
      busy_r        <= 1'b0;
      tx_valid_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      hold_full_r <= hold_full_nxt_s;
      if (hold_load_s) begin
        hold_r <= datain;
      end else begin
        hold_r <= hold_r;
      end
      if (BUFFERED == 1'b1) begin
        slave_ready_r <= ~hold_full_nxt_s;
      end else begin
        slave_ready_r <= (state_nxt_s == IDLE);
      end
      busy_r     <= (state_nxt_s == SHIFT) | hold_full_nxt_s;
      tx_valid_r <= (state_nxt_s == SHIFT);
    end
  end

  tx_shift_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .LSB_FIRST  (LSB_FIRST)
  ) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .srst    (srst),
    .load    (load_s),
    .advance (adv_s),
    .clear   (clr_s),
    .din     (load_word_s),
    .ser_bit (ser_bit_s),
    .last    (last_s)
  );

  assign slave_ready   = slave_ready_r;
  assign busy          = busy_r;
  assign tx_valid      = tx_valid_r;
  assign tx_data       = ser_bit_s;
  assign slave_tx_done = last_s;

endmodule

// File: tb/tb_slave_tx_serializer.sv
// Directed bench for slave_tx_serializer with a per-bit scoreboard.
// dut_a: 8-bit, LSB first, buffered.  dut_b: 12-bit, MSB first, unbuffered.
module tb_slave_tx_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic srst = 1'b0;

  always #5 clk = ~clk;

  logic        mr_a, sv_a;
  logic [7:0]  din_a;
  logic        srdy_a, txd_a, txv_a, done_a, busy_a;
  logic        mr_b, sv_b;
  logic [11:0] din_b;
  logic        srdy_b, txd_b, txv_b, done_b, busy_b;

  slave_tx_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b1), .BUFFERED(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .srst(srst), .master_ready(mr_a), .slave_valid(sv_a),
    .datain(din_a), .slave_ready(srdy_a), .tx_data(txd_a), .tx_valid(txv_a),
    .slave_tx_done(done_a), .busy(busy_a));

  slave_tx_serializer #(.DATA_WIDTH(12), .LSB_FIRST(1'b0), .BUFFERED(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .srst(srst), .master_ready(mr_b), .slave_valid(sv_b),
    .datain(din_b), .slave_ready(srdy_b), .tx_data(txd_b), .tx_valid(txv_b),
    .slave_tx_done(done_b), .busy(busy_b));

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  // Scoreboard entries: {expected tx_data, expected slave_tx_done}
  logic [1:0] qa[$];
  logic [1:0] qb[$];
  logic [1:0] e_a, e_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push the expected bit stream of every accepted word; reset discards all.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
    end else begin
      if (sv_a && mr_a && srdy_a)
        for (int i = 0; i < 8; i++) qa.push_back({din_a[i], (i == 7)});
      if (sv_b && mr_b && srdy_b)
        for (int i = 0; i < 12; i++) qb.push_back({din_b[11 - i], (i == 11)});
    end
  end

  // Compare the serial line of dut_a against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (txv_a) begin
        if (qa.size() == 0) chk("a_unexpected_bit", 64'd1, 64'd0);
        else begin
          e_a = qa.pop_front();
          chk("a_bit", txd_a, e_a[1]);
          chk("a_done", done_a, e_a[0]);
        end
      end else begin
        chk("a_idle_data", txd_a, 1'b0);
        chk("a_idle_done", done_a, 1'b0);
      end
    end
  end

  // Compare the serial line of dut_b against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (txv_b) begin
        if (qb.size() == 0) chk("b_unexpected_bit", 64'd1, 64'd0);
        else begin
          e_b = qb.pop_front();
          chk("b_bit", txd_b, e_b[1]);
          chk("b_done", done_b, e_b[0]);
        end
      end else begin
        chk("b_idle_data", txd_b, 1'b0);
        chk("b_idle_done", done_b, 1'b0);
      end
    end
  end

  // Length of the tx_valid run on dut_a starting at the current cycle.
  task automatic count_a(output int n);
    n = 0;
    for (int g = 0; g < 60; g++) begin
      if (txv_a) n++;
      else if (n > 0) break;
      @(negedge clk);
    end
  endtask

  // Send w1, offer w2 at frame cycle inj; report run length, done positions,
  // slave_ready one cycle after the offer and at frame cycle 8.
  task automatic run_pair(input logic [7:0] w1, input logic [7:0] w2, input int inj,
                          output int n, output int d1, output int d2,
                          output logic r_after, output logic r8);
    sv_a = 1'b1; din_a = w1; mr_a = 1'b1;
    @(negedge clk);
    n = 0; d1 = -1; d2 = -1; r_after = 1'bx; r8 = 1'bx;
    for (int k = 0; k < 60; k++) begin
      if (k == inj) begin sv_a = 1'b1; din_a = w2; end
      else sv_a = 1'b0;
      if (k == inj + 1) r_after = srdy_a;
      if (k == 8) r8 = srdy_a;
      if (txv_a) n++;
      else if (n > 0) break;
      if (done_a) begin
        if (d1 < 0) d1 = k;
        else d2 = k;
      end
      @(negedge clk);
    end
    sv_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n, n1, d1, d2;
    logic r_after, r8;
    mr_a = 1'b0; sv_a = 1'b0; din_a = 8'h00;
    mr_b = 1'b0; sv_b = 1'b0; din_b = 12'h000;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tx_data", txd_a, 1'b0);
    chk("rst_tx_valid", txv_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_ready", srdy_a, 1'b1);
    chk("rst_ready_b", srdy_b, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // 0xA5, LSB first
    sv_a = 1'b1; din_a = 8'hA5; mr_a = 1'b1;
    @(negedge clk);
    sv_a = 1'b0; din_a = 8'h00;
    chk("a5_first_cycle_valid", txv_a, 1'b1);
    chk("a5_busy", busy_a, 1'b1);
    count_a(n);
    chk("a5_len", n, 8);
    chk("a5_idle_busy", busy_a, 1'b0);
    chk("a5_idle_ready", srdy_a, 1'b1);

    // datain changes right after capture
    sv_a = 1'b1; din_a = 8'hFF;
    @(negedge clk);
    sv_a = 1'b0; din_a = 8'h00;
    count_a(n);
    chk("ff_len", n, 8);

    // master_ready low blocks acceptance
    sv_a = 1'b1; din_a = 8'h3C; mr_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("mr_low_valid", txv_a, 1'b0);
      chk("mr_low_busy", busy_a, 1'b0);
    end
    mr_a = 1'b1;
    @(negedge clk);
    sv_a = 1'b0;
    chk("mr_high_accept", txv_a, 1'b1);
    count_a(n);
    chk("mr_len", n, 8);

    // back-to-back through the hold register
    run_pair(8'h11, 8'h22, 0, n, d1, d2, r_after, r8);
    chk("b2b_len", n, 16);
    chk("b2b_done1", d1, 7);
    chk("b2b_done2", d2, 15);
    chk("b2b_hold_full_ready", r_after, 1'b0);
    chk("b2b_hold_drained_ready", r8, 1'b1);

    // accept during the last bit with the hold register empty
    run_pair(8'h5A, 8'h96, 7, n, d1, d2, r_after, r8);
    chk("lastbit_len", n, 16);
    chk("lastbit_done1", d1, 7);
    chk("lastbit_done2", d2, 15);
    chk("lastbit_ready", r_after, 1'b1);

    // reset at bit 4 with a word held
    sv_a = 1'b1; din_a = 8'h77; mr_a = 1'b1;
    @(negedge clk);
    din_a = 8'hE1;
    @(negedge clk);
    sv_a = 1'b0;
    chk("rsthold_ready", srdy_a, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", txv_a, 1'b0);
    chk("midrst_done", done_a, 1'b0);
    chk("midrst_data", txd_a, 1'b0);
    chk("midrst_busy", busy_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_ready", srdy_a, 1'b1);
    chk("post_rst_busy", busy_a, 1'b0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (txv_a) n++;
    end
    chk("held_word_dropped", n, 0);

    // 12-bit MSB-first, unbuffered: one idle cycle between frames
    sv_b = 1'b1; din_b = 12'h8C3; mr_b = 1'b1;
    @(negedge clk);
    din_b = 12'h5A6;
    n = 0; n1 = 0;
    for (int k = 0; k < 60; k++) begin
      if (k == 0) chk("b_ready_in_shift", srdy_b, 1'b0);
      if (k == 11) chk("b_done_at_last", done_b, 1'b1);
      if (k == 12) begin
        chk("b_gap_valid", txv_b, 1'b0);
        chk("b_gap_ready", srdy_b, 1'b1);
      end
      if (k == 13) begin
        chk("b_second_start", txv_b, 1'b1);
        sv_b = 1'b0;
      end
      if (txv_b) begin
        n++;
        if (k < 12) n1++;
      end else if (k > 13) break;
      @(negedge clk);
    end
    chk("b_first_len", n1, 12);
    chk("b_total_len", n, 24);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
